// File: rtl/c7bexu_ldsb.sv
// Load scoreboard for the E stage: tracks outstanding loads in issue order and
// interlocks dependent instructions. Define C7BEXU_LDSB_FWD_EN to forward return data.
module c7bexu_ldsb (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_e,
    input  logic       rs1_ren_e,
    input  logic [4:0] rs2_e,
    input  logic       rs2_ren_e,
    input  logic       ld_vld_e,
    input  logic [4:0] rd_e,
    input  logic       ld_ret_vld,
    output logic       stall_e,
    output logic       ld_iss,
    output logic       ld_ret_wen_w,
    output logic [4:0] ld_ret_rd_w,
    output logic       fwd_rs1_sel,
    output logic       fwd_rs2_sel,
    output logic [2:0] sb_cnt,
    output logic       sb_err
);

    logic [4:0]  fifo [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  cnt;
    logic [31:0] pending;
    logic        err;

    logic [4:0]  head;
    logic        ret_acc;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic        raw1;
    logic        raw2;
    logic        waw;
    logic        full_stall;
    logic [31:0] pend_set;
    logic [31:0] pend_clr;

    assign head         = fifo[rd_ptr];
    assign ret_acc      = ld_ret_vld & (cnt != 3'd0);
    assign ld_ret_rd_w  = head;
    assign ld_ret_wen_w = ret_acc & (head != 5'd0);

`ifdef C7BEXU_LDSB_FWD_EN
    assign fwd_hit1 = ld_ret_wen_w & (rs1_e == ld_ret_rd_w) & rs1_ren_e;
    assign fwd_hit2 = ld_ret_wen_w & (rs2_e == ld_ret_rd_w) & rs2_ren_e;
`else
    assign fwd_hit1 = 1'b0;
    assign fwd_hit2 = 1'b0;
`endif

    assign fwd_rs1_sel = fwd_hit1;
    assign fwd_rs2_sel = fwd_hit2;

    // A WAW hazard holds even when the matching entry returns this cycle, so
    // the pending bit can never be set and cleared on the same edge.
    assign raw1       = rs1_ren_e & (rs1_e != 5'd0) & pending[rs1_e] & ~fwd_hit1;
    assign raw2       = rs2_ren_e & (rs2_e != 5'd0) & pending[rs2_e] & ~fwd_hit2;
    assign waw        = ld_vld_e & (rd_e != 5'd0) & pending[rd_e];
    assign full_stall = ld_vld_e & (cnt == 3'd4) & ~ld_ret_vld;

    assign stall_e = raw1 | raw2 | waw | full_stall;
    assign ld_iss  = ld_vld_e & ~stall_e;
    assign sb_cnt  = cnt;
    assign sb_err  = err;

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (ld_iss && (rd_e != 5'd0)) begin
            pend_set[rd_e] = 1'b1;
        end
        if (ret_acc && (head != 5'd0)) begin
            pend_clr[head] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo[i] <= 5'd0;
            end
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            cnt     <= 3'd0;
            pending <= '0;
            err     <= 1'b0;
        end else begin
            if (ld_iss) begin
                fifo[wr_ptr] <= rd_e;
                wr_ptr       <= wr_ptr + 2'd1;
            end
            if (ret_acc) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({ld_iss, ret_acc})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
            pending <= (pending & ~pend_clr) | pend_set;
            if (ld_ret_vld && (cnt == 3'd0)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_c7bexu_ldsb.sv
// Directed table-driven bench for c7bexu_ldsb; expectations adapt to C7BEXU_LDSB_FWD_EN.
module tb_c7bexu_ldsb;

`ifdef C7BEXU_LDSB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_e;
    logic       rs1_ren_e;
    logic [4:0] rs2_e;
    logic       rs2_ren_e;
    logic       ld_vld_e;
    logic [4:0] rd_e;
    logic       ld_ret_vld;
    logic       stall_e;
    logic       ld_iss;
    logic       ld_ret_wen_w;
    logic [4:0] ld_ret_rd_w;
    logic       fwd_rs1_sel;
    logic       fwd_rs2_sel;
    logic [2:0] sb_cnt;
    logic       sb_err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       ld;
        logic [4:0] rd;
        logic       r1;
        logic [4:0] rs1;
        logic       r2;
        logic [4:0] rs2;
        logic       ret;
        logic       stall;
        logic       iss;
        logic       wen;
        logic [4:0] ret_rd;
        logic       f1;
        logic       f2;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    c7bexu_ldsb dut (
        .clk          (clk),
        .reset        (reset),
        .rs1_e        (rs1_e),
        .rs1_ren_e    (rs1_ren_e),
        .rs2_e        (rs2_e),
        .rs2_ren_e    (rs2_ren_e),
        .ld_vld_e     (ld_vld_e),
        .rd_e         (rd_e),
        .ld_ret_vld   (ld_ret_vld),
        .stall_e      (stall_e),
        .ld_iss       (ld_iss),
        .ld_ret_wen_w (ld_ret_wen_w),
        .ld_ret_rd_w  (ld_ret_rd_w),
        .fwd_rs1_sel  (fwd_rs1_sel),
        .fwd_rs2_sel  (fwd_rs2_sel),
        .sb_cnt       (sb_cnt),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic ld, input logic [4:0] rd,
        input logic r1, input logic [4:0] rs1,
        input logic r2, input logic [4:0] rs2,
        input logic ret,
        input logic stall, input logic iss, input logic wen, input logic [4:0] ret_rd,
        input logic f1, input logic f2, input logic [2:0] cnt, input logic err);
        vec_t v;
        v.ld = ld; v.rd = rd; v.r1 = r1; v.rs1 = rs1; v.r2 = r2; v.rs2 = rs2;
        v.ret = ret; v.stall = stall; v.iss = iss; v.wen = wen; v.ret_rd = ret_rd;
        v.f1 = f1; v.f2 = f2; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        ld_vld_e   = v.ld;
        rd_e       = v.rd;
        rs1_ren_e  = v.r1;
        rs1_e      = v.rs1;
        rs2_ren_e  = v.r2;
        rs2_e      = v.rs2;
        ld_ret_vld = v.ret;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic idle();
        applyStimulus(mk(0,0, 0,0, 0,0, 0, 0,0,0,0, 0,0,0,0));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cnt",   -1, 8'(sb_cnt), 8'd0);
        checkOutput("rst_err",   -1, 8'(sb_err), 8'd0);
        checkOutput("rst_stall", -1, 8'(stall_e), 8'd0);
        checkOutput("rst_wen",   -1, 8'(ld_ret_wen_w), 8'd0);
        reset = 1'b0;

        // Columns: ld rd | r1 rs1 | r2 rs2 | ret || stall iss wen ret_rd f1 f2 cnt err
        vecs.push_back(mk(1,5,  0,0, 0,0, 0,  0,   1,0,0, 0,  0,  0,0));
        vecs.push_back(mk(0,0,  1,5, 0,0, 0,  1,   0,0,0, 0,  0,  1,0));
        vecs.push_back(mk(0,0,  1,5, 0,0, 0,  1,   0,0,0, 0,  0,  1,0));
        vecs.push_back(mk(0,0,  1,5, 0,0, 1,  !FWD,0,1,5, FWD,0,  1,0));
        vecs.push_back(mk(0,0,  1,5, 0,0, 0,  0,   0,0,0, 0,  0,  0,0));
        vecs.push_back(mk(1,0,  0,0, 0,0, 0,  0,   1,0,0, 0,  0,  0,0));
        vecs.push_back(mk(0,0,  1,0, 0,0, 1,  0,   0,0,0, 0,  0,  1,0));
        vecs.push_back(mk(0,0,  0,0, 0,0, 0,  0,   0,0,0, 0,  0,  0,0));
        vecs.push_back(mk(1,1,  0,0, 0,0, 0,  0,   1,0,0, 0,  0,  0,0));
        vecs.push_back(mk(1,2,  0,0, 0,0, 0,  0,   1,0,0, 0,  0,  1,0));
        vecs.push_back(mk(1,3,  0,0, 0,0, 0,  0,   1,0,0, 0,  0,  2,0));
        vecs.push_back(mk(1,4,  0,0, 0,0, 0,  0,   1,0,0, 0,  0,  3,0));
        vecs.push_back(mk(1,6,  0,0, 0,0, 0,  1,   0,0,0, 0,  0,  4,0));
        vecs.push_back(mk(1,6,  0,0, 0,0, 1,  0,   1,1,1, 0,  0,  4,0));
        vecs.push_back(mk(0,0,  0,0, 1,3, 1,  1,   0,1,2, 0,  0,  4,0));
        vecs.push_back(mk(0,0,  0,0, 1,3, 1,  !FWD,0,1,3, 0,  FWD,3,0));
        vecs.push_back(mk(0,0,  1,1, 0,0, 1,  0,   0,1,4, 0,  0,  2,0));
        vecs.push_back(mk(0,0,  0,0, 0,0, 1,  0,   0,1,6, 0,  0,  1,0));
        vecs.push_back(mk(0,0,  0,0, 0,0, 0,  0,   0,0,0, 0,  0,  0,0));
        vecs.push_back(mk(1,7,  0,0, 0,0, 0,  0,   1,0,0, 0,  0,  0,0));
        vecs.push_back(mk(1,7,  0,0, 0,0, 0,  1,   0,0,0, 0,  0,  1,0));
        vecs.push_back(mk(1,7,  0,0, 0,0, 1,  1,   0,1,7, 0,  0,  1,0));
        vecs.push_back(mk(1,7,  0,0, 0,0, 0,  0,   1,0,0, 0,  0,  0,0));
        vecs.push_back(mk(0,0,  0,0, 0,0, 1,  0,   0,1,7, 0,  0,  1,0));
        vecs.push_back(mk(0,0,  0,0, 0,0, 0,  0,   0,0,0, 0,  0,  0,0));
        vecs.push_back(mk(0,0,  0,0, 0,0, 1,  0,   0,0,0, 0,  0,  0,0));
        vecs.push_back(mk(0,0,  0,0, 0,0, 0,  0,   0,0,0, 0,  0,  0,1));
        vecs.push_back(mk(0,0,  0,0, 0,0, 0,  0,   0,0,0, 0,  0,  0,1));
        vecs.push_back(mk(1,9,  0,0, 0,0, 0,  0,   1,0,0, 0,  0,  0,1));
        vecs.push_back(mk(1,10, 0,0, 0,0, 0,  0,   1,0,0, 0,  0,  1,1));

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput("stall_e", i, 8'(stall_e), 8'(vecs[i].stall));
            checkOutput("ld_iss",  i, 8'(ld_iss), 8'(vecs[i].iss));
            checkOutput("ret_wen", i, 8'(ld_ret_wen_w), 8'(vecs[i].wen));
            if (vecs[i].wen) begin
                checkOutput("ret_rd", i, 8'(ld_ret_rd_w), 8'(vecs[i].ret_rd));
            end
            checkOutput("fwd_rs1", i, 8'(fwd_rs1_sel), 8'(vecs[i].f1));
            checkOutput("fwd_rs2", i, 8'(fwd_rs2_sel), 8'(vecs[i].f2));
            checkOutput("sb_cnt",  i, 8'(sb_cnt), 8'(vecs[i].cnt));
            checkOutput("sb_err",  i, 8'(sb_err), 8'(vecs[i].err));
        end

        // Two loads (x9, x10) outstanding; an async reset must discard them.
        @(negedge clk);
        idle();
        rs1_ren_e = 1'b1;
        rs1_e     = 5'd9;
        #1;
        checkOutput("pre_rst_cnt",   100, 8'(sb_cnt), 8'd2);
        checkOutput("pre_rst_stall", 100, 8'(stall_e), 8'd1);
        reset = 1'b1;
        #1;
        checkOutput("async_rst_cnt",   101, 8'(sb_cnt), 8'd0);
        checkOutput("async_rst_err",   101, 8'(sb_err), 8'd0);
        checkOutput("async_rst_stall", 101, 8'(stall_e), 8'd0);
        ld_ret_vld = 1'b1;
        #1;
        checkOutput("rst_ret_wen", 102, 8'(ld_ret_wen_w), 8'd0);
        ld_ret_vld = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rs2_ren_e = 1'b1;
        rs2_e     = 5'd10;
        ld_ret_vld = 1'b1;
        #1;
        checkOutput("post_rst_stall", 103, 8'(stall_e), 8'd0);
        checkOutput("post_rst_wen",   103, 8'(ld_ret_wen_w), 8'd0);
        @(negedge clk);
        idle();
        #1;
        checkOutput("post_rst_err", 104, 8'(sb_err), 8'd1);
        checkOutput("post_rst_cnt", 104, 8'(sb_cnt), 8'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
